seg7_multi_digit_driver: RTL and testbench

Parametrised successor to the team's fixed two-digit hex display decoder. Converts a WIDTH-bit unsigned value to DIGITS active-low seven-segment digits, in hex or decimal. Decimal conversion is a sequential shift-and-add-3 (double-dabble) engine. Adds leading-zero blanking, overflow indication and a start/busy/done handshake. Sits between lab datapaths (counters, ALU results) and the board's seven-segment displays.

---
 rtl/seg7_multi_digit_driver.sv | 179 +++++++++++++++++
 tb/tb_seg7_multi_digit_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_digit_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_multi_digit_driver
// Brief   : WIDTH-bit value to DIGITS active-low 7-segment digits, hex or
//           decimal (serial double-dabble), with blanking and overflow dashes.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_multi_digit_driver #(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   input  logic                  dec_mode,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [7*DIGITS-1:0]   seg_out
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [6:0] c_blank = 7'b1111111;
   localparam logic [6:0] c_dash  = 7'b0111111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_UPDATE = 2'd2
   } state_t;

   state_t                state_q;
   logic [WIDTH-1:0]      opnd_q;
   logic                  dec_q;
   logic                  blz_q;
   logic [BW-1:0]         bcd_q;
   logic                  sticky_q;
   logic [CW-1:0]         cnt_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  ovf_q;
   logic [7*DIGITS-1:0]   seg_q;

   logic [BW-1:0]         bcd_adj;
   logic [BW-1:0]         bcd_d;
   logic [WIDTH-1:0]      opnd_d;
   logic                  carry_out;
   logic [BW-1:0]         hex_nib;
   logic                  hex_ovf;
   logic [BW-1:0]         nib;
   logic                  ovf_d;
   logic [7*DIGITS-1:0]   seg_d;
   logic                  lz_seen;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0:    glyph = 7'b1000000;
         4'h1:    glyph = 7'b1111001;
         4'h2:    glyph = 7'b0100100;
         4'h3:    glyph = 7'b0110000;
         4'h4:    glyph = 7'b0011001;
         4'h5:    glyph = 7'b0010010;
         4'h6:    glyph = 7'b0000010;
         4'h7:    glyph = 7'b1111000;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0010000;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b0000011;
         4'hC:    glyph = 7'b1000110;
         4'hD:    glyph = 7'b0100001;
         4'hE:    glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // One double-dabble step: correct nibbles, then shift operand MSB into BCD.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      {carry_out, bcd_d, opnd_d} = {bcd_adj, opnd_q, 1'b0};
   end

   generate
      if (WIDTH >= BW) begin : g_hex_trunc
         assign hex_nib = opnd_q[BW-1:0];
      end else begin : g_hex_ext
         assign hex_nib = {{(BW - WIDTH){1'b0}}, opnd_q};
      end

      if (WIDTH > BW) begin : g_hex_ovf
         assign hex_ovf = |opnd_q[WIDTH-1:BW];
      end else begin : g_hex_no_ovf
         assign hex_ovf = 1'b0;
      end
   endgenerate

   assign nib   = dec_q ? bcd_q : hex_nib;
   assign ovf_d = dec_q ? sticky_q : hex_ovf;

   // Scan from the top digit; digits before the first nonzero one may blank.
   always_comb begin
      seg_d   = '1;
      lz_seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (nib[4*i +: 4] != 4'd0 || i == 0) begin
            lz_seen = 1'b1;
         end
         if (ovf_d) begin
            seg_d[7*i +: 7] = c_dash;
         end else if (blz_q && !lz_seen) begin
            seg_d[7*i +: 7] = c_blank;
         end else begin
            seg_d[7*i +: 7] = glyph(nib[4*i +: 4]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         opnd_q   <= '0;
         dec_q    <= 1'b0;
         blz_q    <= 1'b0;
         bcd_q    <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         seg_q    <= '1;
      end else begin
         done_q <= 1'b0;
         busy_q <= (state_q == S_SHIFT);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  opnd_q   <= value;
                  dec_q    <= dec_mode;
                  blz_q    <= blank_lz;
                  bcd_q    <= '0;
                  sticky_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= dec_mode ? S_SHIFT : S_UPDATE;
               end
            end
            S_SHIFT: begin
               bcd_q    <= bcd_d;
               opnd_q   <= opnd_d;
               sticky_q <= sticky_q | carry_out;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               seg_q   <= seg_d;
               ovf_q   <= ovf_d;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign seg_out  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_multi_digit_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_multi_digit_driver
// Brief   : Directed scoreboard bench for two configurations (6b/2d, 8b/2d).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_multi_digit_driver;

   typedef struct packed {
      logic        ovf;
      logic [13:0] seg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, dec_a, blz_a, busy_a, done_a, ovf_a;
   logic [5:0]  value_a;
   logic [13:0] seg_a;
   logic        start_b, dec_b, blz_b, busy_b, done_b, ovf_b;
   logic [7:0]  value_b;
   logic [13:0] seg_b;

   bit          sel;
   logic        done_s, busy_s, ovf_s;
   logic [13:0] seg_s;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   seg7_multi_digit_driver #(.WIDTH(6), .DIGITS(2)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .value(value_a),
      .dec_mode(dec_a), .blank_lz(blz_a), .busy(busy_a), .done(done_a),
      .overflow(ovf_a), .seg_out(seg_a)
   );

   seg7_multi_digit_driver #(.WIDTH(8), .DIGITS(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .value(value_b),
      .dec_mode(dec_b), .blank_lz(blz_b), .busy(busy_b), .done(done_b),
      .overflow(ovf_b), .seg_out(seg_b)
   );

   assign done_s = sel ? done_b : done_a;
   assign busy_s = sel ? busy_b : busy_a;
   assign ovf_s  = sel ? ovf_b  : ovf_a;
   assign seg_s  = sel ? seg_b  : seg_a;

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         9:       return 7'b0010000;
         10:      return 7'b0001000;
         11:      return 7'b0000011;
         12:      return 7'b1000110;
         13:      return 7'b0100001;
         14:      return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Reference image built from division/modulo, two digits per display.
   function automatic exp_t model(input int v, input bit dec, input bit blz);
      exp_t e;
      int   d[2];
      bit   seen;
      if (dec) begin
         e.ovf = (v >= 100);
         d[0]  = v % 10;
         d[1]  = (v / 10) % 10;
      end else begin
         e.ovf = ((v >> 8) != 0);
         d[0]  = v & 15;
         d[1]  = (v >> 4) & 15;
      end
      seen = 1'b0;
      for (int i = 1; i >= 0; i--) begin
         if (d[i] != 0 || i == 0) seen = 1'b1;
         if (e.ovf)              e.seg[7*i +: 7] = 7'b0111111;
         else if (blz && !seen)  e.seg[7*i +: 7] = 7'b1111111;
         else                    e.seg[7*i +: 7] = glyph(d[i]);
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit s, input bit st, input int v, input bit dec, input bit blz);
      if (s) begin
         start_b = st; value_b = 8'(v); dec_b = dec; blz_b = blz;
      end else begin
         start_a = st; value_a = 6'(v); dec_a = dec; blz_a = blz;
      end
   endtask

   task automatic convert(input bit s, input int v, input bit dec, input bit blz);
      int   w, lat, busy_cnt;
      exp_t e;
      sel = s;
      w   = s ? 8 : 6;
      drive(s, 1'b1, v, dec, blz);
      sb_q.push_back(model(v, dec, blz));
      tick();
      drive(s, 1'b0, 0, 1'b0, 1'b0);
      busy_cnt = busy_s ? 1 : 0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (done_s) begin
            lat = k;
            break;
         end
         if (busy_s) busy_cnt++;
      end
      e = sb_q.pop_front();
      if (lat == 0) begin
         chk("done_timeout", 32'd0, 32'd1);
         return;
      end
      chk("latency", lat, dec ? w + 1 : 1);
      chk("busy_cycles", busy_cnt, dec ? w : 0);
      chk("busy_in_done", 32'(busy_s), 32'd0);
      chk("seg_out", 32'(seg_s), 32'(e.seg));
      chk("overflow", 32'(ovf_s), 32'(e.ovf));
      tick();
      chk("done_one_cycle", 32'(done_s), 32'd0);
   endtask

   initial begin : main
      int   dones, first_k;
      bit   stable;
      exp_t e, held;

      rst = 1'b1;
      sel = 1'b0;
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      chk("rst_seg_a", 32'(seg_a), 32'h3fff);
      chk("rst_seg_b", 32'(seg_b), 32'h3fff);
      chk("rst_busy_done_ovf", {busy_a, done_a, ovf_a, busy_b, done_b, ovf_b}, 32'd0);

      convert(1'b0, 45, 1'b0, 1'b0);
      convert(1'b0, 45, 1'b1, 1'b0);
      convert(1'b0, 7,  1'b1, 1'b1);
      convert(1'b0, 0,  1'b1, 1'b1);
      convert(1'b0, 0,  1'b0, 1'b0);
      convert(1'b0, 63, 1'b1, 1'b0);
      convert(1'b0, 10, 1'b0, 1'b1);
      convert(1'b1, 200, 1'b1, 1'b0);
      convert(1'b1, 200, 1'b0, 1'b0);
      convert(1'b1, 99,  1'b1, 1'b1);
      convert(1'b1, 100, 1'b1, 1'b1);
      tick(); tick(); tick();
      chk("overflow_held", 32'(ovf_b), 32'd1);
      convert(1'b1, 255, 1'b1, 1'b0);
      convert(1'b1, 5,   1'b1, 1'b0);

      // A start during SHIFT, and input churn, must not disturb the conversion.
      sel = 1'b0;
      drive(1'b0, 1'b1, 45, 1'b1, 1'b0);
      e = model(45, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 45, 1'b1, 1'b0);
      tick();
      tick();
      drive(1'b0, 1'b1, 10, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
      dones   = 0;
      first_k = 0;
      for (int k = 4; k <= 20; k++) begin
         tick();
         if (done_a) begin
            dones++;
            if (first_k == 0) begin
               first_k = k;
               chk("ignored_start_seg", 32'(seg_a), 32'(e.seg));
            end
         end
      end
      chk("ignored_start_dones", dones, 1);
      chk("ignored_start_latency", first_k, 7);

      // Reset four cycles into a decimal conversion aborts it silently.
      drive(1'b0, 1'b1, 45, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 45, 1'b1, 1'b0);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_seg", 32'(seg_a), 32'h3fff);
      chk("abort_busy_done_ovf", {busy_a, done_a, ovf_a}, 32'd0);
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done_a) dones++;
      end
      chk("abort_no_done", dones, 0);

      // start held high: 63 then 12, each result exactly once.
      drive(1'b0, 1'b1, 63, 1'b1, 1'b0);
      sb_q.push_back(model(63, 1'b1, 1'b0));
      sb_q.push_back(model(12, 1'b1, 1'b0));
      held   = '0;
      dones  = 0;
      stable = 1'b1;
      tick();
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (done_a) begin
            dones++;
            e = sb_q.pop_front();
            chk("b2b_seg", 32'(seg_a), 32'(e.seg));
            held = e;
            if (dones == 1) begin
               value_a = 6'd12;
            end else begin
               start_a = 1'b0;
               break;
            end
         end else if (dones == 1 && seg_a !== held.seg) begin
            stable = 1'b0;
         end
      end
      start_a = 1'b0;
      chk("b2b_dones", dones, 2);
      chk("b2b_stable", 32'(stable), 32'd1);
      dones = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done_a) dones++;
      end
      chk("b2b_no_extra", dones, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
